// File: rtl/axis_pkt_pkg.sv
// Shared types and config-word helpers for the AXI-Stream packet generator.
package axis_pkt_pkg;

  localparam int unsigned PKT_DW = 8;
  localparam int unsigned CFG_W  = 2 * PKT_DW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } pkt_state_e;

  function automatic logic [PKT_DW-1:0] cfg_len_m1(input logic [CFG_W-1:0] cfg);
    return cfg[CFG_W-1:PKT_DW];
  endfunction

  function automatic logic [PKT_DW-1:0] cfg_seed(input logic [CFG_W-1:0] cfg);
    return cfg[PKT_DW-1:0];
  endfunction

endpackage

// File: rtl/axis_pkt_gen.sv
// AXI-Stream packet source: {len_m1, seed} config, incrementing data, optional repeat.
// Define PKT_GEN_GAP_EN to insert GAP idle cycles after every packet.
module axis_pkt_gen
  import axis_pkt_pkg::*;
#(
  parameter int unsigned DW = 8,
  parameter int unsigned CW = 16
`ifdef PKT_GEN_GAP_EN
  ,
  parameter int unsigned GAP = 4
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            repeat_en,
  input  logic [2*DW-1:0] config_packet,
  output logic [DW-1:0]   m_tdata,
  output logic            m_tvalid,
  output logic            m_tlast,
  input  logic            m_tready,
  output logic            busy,
  output logic            pkt_done,
  output logic [CW-1:0]   pkt_count
);

  // One extra bit so len_m1 = all-ones still counts 2^DW beats.
  localparam int unsigned BW = DW + 1;
`ifdef PKT_GEN_GAP_EN
  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;
`endif

  pkt_state_e     state, state_nxt;
  logic [DW-1:0]  len_q, len_nxt;
  logic [DW-1:0]  seed_q, seed_nxt;
  logic [BW-1:0]  beat_q, beat_nxt;
  logic [DW-1:0]  tdata_nxt;
  logic           tvalid_nxt, tlast_nxt, busy_nxt, done_nxt;
  logic [CW-1:0]  count_nxt;
  logic           launch;
  logic           hs, last_hs;
`ifdef PKT_GEN_GAP_EN
  logic [GW-1:0]  gap_q, gap_nxt;
  logic           rep_q, rep_nxt;
`endif

  assign hs      = m_tvalid & m_tready;
  assign last_hs = hs & m_tlast;

  // Next-state and next-output logic; launch presents beat 0 of a new packet.
  always_comb begin
    state_nxt  = state;
    len_nxt    = len_q;
    seed_nxt   = seed_q;
    beat_nxt   = beat_q;
    tdata_nxt  = m_tdata;
    tvalid_nxt = m_tvalid;
    tlast_nxt  = m_tlast;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    count_nxt  = pkt_count;
    launch     = 1'b0;
`ifdef PKT_GEN_GAP_EN
    gap_nxt    = gap_q;
    rep_nxt    = rep_q;
`endif

    case (state)
      IDLE: begin
        if (start) begin
          len_nxt  = config_packet[2*DW-1:DW];
          seed_nxt = config_packet[DW-1:0];
          launch   = 1'b1;
        end
      end
      SEND: begin
        if (last_hs) begin
          count_nxt  = pkt_count + CW'(1);
          done_nxt   = 1'b1;
          tvalid_nxt = 1'b0;
          tlast_nxt  = 1'b0;
`ifdef PKT_GEN_GAP_EN
          state_nxt  = axis_pkt_pkg::GAP;
          gap_nxt    = GW'(GAP - 1);
          rep_nxt    = repeat_en;
`else
          if (repeat_en) begin
            launch = 1'b1;
          end else begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
          end
`endif
        end else if (hs) begin
          beat_nxt  = beat_q + BW'(1);
          tdata_nxt = m_tdata + DW'(1);
          tlast_nxt = (beat_q + BW'(1)) == {1'b0, len_q};
        end
      end
`ifdef PKT_GEN_GAP_EN
      axis_pkt_pkg::GAP: begin
        if (gap_q == '0) begin
          if (rep_q) begin
            launch = 1'b1;
          end else begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
          end
        end else begin
          gap_nxt = gap_q - GW'(1);
        end
      end
`endif
      default: begin
        state_nxt  = IDLE;
        tvalid_nxt = 1'b0;
        tlast_nxt  = 1'b0;
        busy_nxt   = 1'b0;
      end
    endcase

    if (launch) begin
      state_nxt  = SEND;
      busy_nxt   = 1'b1;
      beat_nxt   = '0;
      tdata_nxt  = seed_nxt;
      tvalid_nxt = 1'b1;
      tlast_nxt  = (len_nxt == '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      len_q     <= '0;
      seed_q    <= '0;
      beat_q    <= '0;
      m_tdata   <= '0;
      m_tvalid  <= 1'b0;
      m_tlast   <= 1'b0;
      busy      <= 1'b0;
      pkt_done  <= 1'b0;
      pkt_count <= '0;
`ifdef PKT_GEN_GAP_EN
      gap_q     <= '0;
      rep_q     <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      len_q     <= len_nxt;
      seed_q    <= seed_nxt;
      beat_q    <= beat_nxt;
      m_tdata   <= tdata_nxt;
      m_tvalid  <= tvalid_nxt;
      m_tlast   <= tlast_nxt;
      busy      <= busy_nxt;
      pkt_done  <= done_nxt;
      pkt_count <= count_nxt;
`ifdef PKT_GEN_GAP_EN
      gap_q     <= gap_nxt;
      rep_q     <= rep_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Scoreboard bench for axis_pkt_gen: expected beats queued at start, checked at handshake.
module tb_axis_pkt_gen;
  import axis_pkt_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 16;
`ifdef PKT_GEN_GAP_EN
  localparam int GAP_CYC = 4;
`else
  localparam int GAP_CYC = 0;
`endif

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              repeat_en = 1'b0;
  logic [CFG_W-1:0]  config_packet = '0;
  logic [DW-1:0]     m_tdata;
  logic              m_tvalid;
  logic              m_tlast;
  logic              m_tready = 1'b1;
  logic              busy;
  logic              pkt_done;
  logic [CW-1:0]     pkt_count;

  int     checks = 0;
  int     failures = 0;
  beat_t  sb[$];
  int     cnt_model = 0;
  bit     rand_ready = 1'b0;

  axis_pkt_gen #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .repeat_en(repeat_en),
    .config_packet(config_packet), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
    .m_tlast(m_tlast), .m_tready(m_tready), .busy(busy),
    .pkt_done(pkt_done), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_cfg(input logic [CFG_W-1:0] cfg);
    logic [DW-1:0] len;
    logic [DW-1:0] seed;
    len  = cfg_len_m1(cfg);
    seed = cfg_seed(cfg);
    for (int i = 0; i <= int'(len); i++) begin
      sb.push_back('{data: DW'(int'(seed) + i), last: (i == int'(len))});
    end
  endtask

  // Caller is positioned just after a rising edge.
  task automatic start_pkt(input logic [CFG_W-1:0] cfg);
    config_packet = cfg;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  // Ready driver: random or held high, updated just after each rising edge.
  initial begin
    forever begin
      @(posedge clk); #1;
      m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: scoreboard pop, stall stability, pkt_done/pkt_count timing.
  initial begin
    bit            stall;
    bit            done_exp;
    logic [DW-1:0] hold_data;
    logic          hold_last;
    beat_t         e;
    stall = 1'b0;
    done_exp = 1'b0;
    hold_data = '0;
    hold_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        stall = 1'b0;
        done_exp = 1'b0;
        continue;
      end
      if (done_exp || pkt_done) begin
        check("pkt_done", 32'(pkt_done), 32'(done_exp));
        if (done_exp) check("pkt_count", 32'(pkt_count), 32'(cnt_model));
      end
      if (stall) begin
        check("hold_valid", 32'(m_tvalid), 32'd1);
        check("hold_data", 32'(m_tdata), 32'(hold_data));
        check("hold_last", 32'(m_tlast), 32'(hold_last));
      end
      if (m_tvalid && m_tready) begin
        if (sb.size() == 0) begin
          check("extra_beat", 32'(m_tdata), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("beat_data", 32'(m_tdata), 32'(e.data));
          check("beat_last", 32'(m_tlast), 32'(e.last));
        end
        if (m_tlast) cnt_model = (cnt_model + 1) % (1 << CW);
      end
      done_exp  = m_tvalid && m_tready && m_tlast;
      stall     = m_tvalid && !m_tready;
      hold_data = m_tdata;
      hold_last = m_tlast;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_tdata", 32'(m_tdata), 32'd0);
    check("rst_tlast", 32'(m_tlast), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(pkt_done), 32'd0);
    check("rst_count", 32'(pkt_count), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Single packet, latency 1
    check("idle_valid", 32'(m_tvalid), 32'd0);
    push_cfg(16'h0310);
    start_pkt(16'h0310);
    check("first_valid_lat", 32'(m_tvalid), 32'd1);
    check("first_data", 32'(m_tdata), 32'h10);
    wait_idle(100);
    check("count_after_1", 32'(pkt_count), 32'd1);

    // Seed wrap
    push_cfg(16'h03FE);
    start_pkt(16'h03FE);
    wait_idle(100);

    // Single-beat packet
    push_cfg(16'h0077);
    start_pkt(16'h0077);
    check("one_beat_last", 32'(m_tlast), 32'd1);
    wait_idle(100);

    // Back-pressure
    rand_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push_cfg(16'h0700);
      start_pkt(16'h0700);
      wait_idle(400);
    end
    rand_ready = 1'b0;
    @(posedge clk); #1;
    check("count_after_bp", 32'(pkt_count), 32'd6);

    // Repeat: three packets, then repeat_en dropped
    base = int'(pkt_count);
    repeat_en = 1'b1;
    for (int k = 0; k < 3; k++) push_cfg(16'h0120);
    start_pkt(16'h0120);
    n = 0;
    while (busy && n < 200) begin
      if (int'(pkt_count) == base + 2) repeat_en = 1'b0;
      n++;
      @(posedge clk); #1;
    end
    repeat_en = 1'b0;
    check("repeat_busy_cycles", 32'(n), 32'(6 + 3 * GAP_CYC));
    wait_idle(100);
    check("repeat_count", 32'(pkt_count), 32'(base + 3));

    // Start and config change mid-packet are ignored
    base = int'(pkt_count);
    push_cfg(16'h0340);
    start_pkt(16'h0340);
    @(posedge clk); #1;
    config_packet = 16'h0599;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(100);
    repeat (4) @(posedge clk);
    #1;
    check("no_queued_valid", 32'(m_tvalid), 32'd0);
    check("no_queued_count", 32'(pkt_count), 32'(base + 1));

    // Start coinciding with last-beat handshake is ignored
    push_cfg(16'h0150);
    start_pkt(16'h0150);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(100);
    repeat (4) @(posedge clk);
    #1;
    check("last_start_busy", 32'(busy), 32'd0);
    check("last_start_count", 32'(pkt_count), 32'(base + 2));

    // Reset mid-packet at beat 2
    push_cfg(16'h0700);
    start_pkt(16'h0700);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    #1;
    check("mid_rst_tvalid", 32'(m_tvalid), 32'd0);
    check("mid_rst_tdata", 32'(m_tdata), 32'd0);
    check("mid_rst_tlast", 32'(m_tlast), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_count", 32'(pkt_count), 32'd0);
    sb.delete();
    cnt_model = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_valid", 32'(m_tvalid), 32'd0);
    check("post_rst_done", 32'(pkt_done), 32'd0);
    check("post_rst_count", 32'(pkt_count), 32'd0);

    // Fresh packet after reset
    push_cfg(16'h0230);
    start_pkt(16'h0230);
    wait_idle(100);
    check("post_rst_pkt_count", 32'(pkt_count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_pkt_gen.md
Name: axis_pkt_gen

Overview:
- AXI-Stream packet source: the transmitter that drives the s_* slave side of the packet adder datapath.
- Emits packets whose length and data seed come from the same {length, seed} config_packet word the adder consumes.
- Supplies stimulus and in-system traffic for the FIFO/adder chain.
- Honours m_tready back-pressure, counts completed packets, and can auto-repeat.

Parameters:
- DW, 8, data width; config_packet is 2*DW bits wide.
- CW, 16, width of the completed-packet counter.
- GAP, 4, idle cycles inserted between packets (used only when PKT_GEN_GAP_EN is defined; must be >= 1).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  single-cycle request to begin a packet; sampled only in IDLE.
- repeat_en  input  1  level; sampled on the last-beat handshake; 1 = start the next packet with the latched config.
- config_packet  input  2*DW  {len_m1[2*DW-1:DW], seed[DW-1:0]}; sampled only on an accepted start.
- m_tdata  output  DW  stream data.
- m_tvalid  output  1  stream valid.
- m_tlast  output  1  marks the final beat of the packet.
- m_tready  input  1  downstream ready.
- busy  output  1  high in every state except IDLE.
- pkt_done  output  1  one-cycle pulse the cycle after a last-beat handshake.
- pkt_count  output  CW  number of completed packets; wraps.

Behaviour:
- Reset (asynchronous, rst=0):
  - m_tdata=0, m_tvalid=0, m_tlast=0, busy=0, pkt_done=0, pkt_count=0.
  - FSM goes to IDLE and latched config is cleared.
  - Reset mid-packet abandons the packet with no resume and no pkt_done.
- All outputs are registered.
- Handshake:
  - A beat transfers when m_tvalid & m_tready.
  - While m_tvalid=1 and m_tready=0, m_tdata, m_tvalid and m_tlast hold stable.
  - m_tvalid is never dropped before the beat transfers.
- Packet content:
  - Beats per packet = len_m1+1 (1..2^DW).
  - Beat i carries (seed+i) mod 2^DW; wrap is silent.
  - m_tlast=1 only on beat len_m1.
  - The beat counter is DW+1 bits internally so len_m1 = all-ones produces 2^DW beats.
- FSM states: IDLE, SEND, GAP (GAP exists only with the macro).
  - IDLE: start=1 latches config and moves to SEND. The first beat is valid the next cycle (latency 1). Start in any other state is ignored.
  - SEND: advances one beat per handshake. On the last-beat handshake:
    - pkt_count increments (wraps 2^CW-1 -> 0).
    - pkt_done pulses the following cycle.
    - Next state is SEND if repeat_en=1, otherwise IDLE.
  - Repeat without the macro: the next packet's first beat (seed again) is presented in the cycle immediately after the last-beat handshake, with no bubble.
- Simultaneous events:
  - start together with an in-flight last-beat handshake is ignored.
  - A config_packet change while busy has no effect until the next accepted start.
- m_tready=1 permanently gives a throughput of 1 beat/cycle.

Optional Feature:
- Macro: PKT_GEN_GAP_EN.
- Defined:
  - After every last-beat handshake the FSM enters GAP for exactly GAP cycles with m_tvalid=0 and busy=1.
  - It then goes to SEND if repeat_en was 1 at the last beat, otherwise IDLE.
  - start is ignored during GAP.
- Undefined:
  - No GAP state or counter is present.
  - Behaviour is back-to-back as described above.

Decomposition:
- Package axis_pkt_pkg holds:
  - typedef enum logic [1:0] pkt_state_e {IDLE, SEND, GAP}.
  - Function cfg_len_m1() and function cfg_seed() to slice config_packet.
  - localparam CFG_W = 2*DW.
- No sub-module is needed. The FSM, beat counter and gap counter live in one always_ff block plus next-state logic.

Test Plan:
- Single packet, no back-pressure: config {0x03, 0x10}, start, m_tready=1 -> data 0x10,0x11,0x12,0x13; m_tlast only on 0x13; first valid 1 cycle after start; pkt_count=1; one pkt_done pulse.
- Seed wrap: config {0x03, 0xFE} -> data 0xFE,0xFF,0x00,0x01.
- Back-pressure: config {0x07, 0x00}, m_tready toggled randomly -> data held stable while stalled; all 8 beats delivered in order exactly once.
- Repeat: repeat_en=1, config {0x01, 0x20}, m_tready=1 -> stream 0x20,0x21,0x20,0x21,... with no bubble (macro off); deassert repeat_en -> stops after the current packet.
- Ignored start / config change: pulse start and change config mid-packet -> current packet unaffected; no second packet is queued.
- Reset mid-packet, and gap (PKT_GEN_GAP_EN, GAP=4):
  - Drop rst at beat 2 -> all outputs 0 immediately; pkt_count=0.
  - With the macro and repeat_en=1 -> exactly 4 idle cycles between packets.
